// File: rtl/abs_cmd_fsm.sv
// rtl/abs_cmd_fsm.sv - abstract-command engine for the debug module
//
// Decodes the abstract command register, validates it, runs a request/ack
// access against the core register file and reports busy/cmderr status.
//
// Ports:
//   i_sys_clk, i_sys_rstn        clock, asynchronous active-low reset
//   i_command, i_cmd_update      command register value and write strobe
//   i_data0                      data0 value used as write data
//   i_hart_halted                access only allowed while halted
//   i_cmderr_clr                 W1C strobe for abstractcs.cmderr
//   o_cmd_busy, o_cmderr         abstractcs.busy / abstractcs.cmderr
//   o_cmd_finished               one-cycle completion pulse
//   o_data0_wr, o_data0_wdata    read-back data into data0
//   o_regno_inc, o_regno_next    postincrement write-back of command.regno
//   o_reg_req .. o_reg_wdata     register access request towards the core
//   i_reg_ack, i_reg_err, i_reg_rdata   access response from the core
module abs_cmd_fsm #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGNO_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rstn,
  input  logic [31:0]            i_command,
  input  logic                   i_cmd_update,
  input  logic [DATA_WIDTH-1:0]  i_data0,
  input  logic                   i_hart_halted,
  input  logic                   i_cmderr_clr,
  output logic                   o_cmd_busy,
  output logic [2:0]             o_cmderr,
  output logic                   o_cmd_finished,
  output logic                   o_data0_wr,
  output logic [DATA_WIDTH-1:0]  o_data0_wdata,
  output logic                   o_regno_inc,
  output logic [REGNO_WIDTH-1:0] o_regno_next,
  output logic                   o_reg_req,
  output logic                   o_reg_wr1_rd0,
  output logic [REGNO_WIDTH-1:0] o_reg_regno,
  output logic [DATA_WIDTH-1:0]  o_reg_wdata,
  input  logic                   i_reg_ack,
  input  logic                   i_reg_err,
  input  logic [DATA_WIDTH-1:0]  i_reg_rdata
);

  localparam logic [2:0] LEGAL_AARSIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam int         CNT_W         = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [2:0]             r_cmderr, w_cmderr_nxt;
  logic                   r_fin, w_fin_nxt;
  logic                   r_d0wr, w_d0wr_nxt;
  logic [DATA_WIDTH-1:0]  r_d0data, w_d0data_nxt;
  logic                   r_rinc, w_rinc_nxt;
  logic [REGNO_WIDTH-1:0] r_rnext, w_rnext_nxt;
  logic                   r_req, w_req_nxt;
  logic                   r_wr, w_wr_nxt;
  logic [REGNO_WIDTH-1:0] r_regno, w_regno_nxt;
  logic [DATA_WIDTH-1:0]  r_wdata, w_wdata_nxt;
  logic                   r_postinc, w_postinc_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   w_err_set;
  logic [2:0]             w_err_code;

  logic [7:0]             w_cmdtype;
  logic [2:0]             w_aarsize;
  logic                   w_postinc, w_transfer, w_write;
  logic [REGNO_WIDTH-1:0] w_cmd_regno;
  logic                   w_unused;

  assign w_cmdtype   = i_command[31:24];
  assign w_aarsize   = i_command[22:20];
  assign w_postinc   = i_command[19];
  assign w_transfer  = i_command[17];
  assign w_write     = i_command[16];
  assign w_cmd_regno = i_command[REGNO_WIDTH-1:0];
  assign w_unused    = ^{i_command[23], i_command[18]};

  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_cmderr  <= 3'd0;
      r_fin     <= 1'b0;
      r_d0wr    <= 1'b0;
      r_d0data  <= '0;
      r_rinc    <= 1'b0;
      r_rnext   <= '0;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_regno   <= '0;
      r_wdata   <= '0;
      r_postinc <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_cmderr  <= w_cmderr_nxt;
      r_fin     <= w_fin_nxt;
      r_d0wr    <= w_d0wr_nxt;
      r_d0data  <= w_d0data_nxt;
      r_rinc    <= w_rinc_nxt;
      r_rnext   <= w_rnext_nxt;
      r_req     <= w_req_nxt;
      r_wr      <= w_wr_nxt;
      r_regno   <= w_regno_nxt;
      r_wdata   <= w_wdata_nxt;
      r_postinc <= w_postinc_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Completion pulses are computed on the transition into DONE (or on a
  // rejection in IDLE) and registered, so they appear one cycle later.
  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_fin_nxt     = 1'b0;
    w_d0wr_nxt    = 1'b0;
    w_d0data_nxt  = r_d0data;
    w_rinc_nxt    = 1'b0;
    w_rnext_nxt   = r_rnext;
    w_req_nxt     = r_req;
    w_wr_nxt      = r_wr;
    w_regno_nxt   = r_regno;
    w_wdata_nxt   = r_wdata;
    w_postinc_nxt = r_postinc;
    w_cnt_nxt     = r_cnt;
    w_err_set     = 1'b0;
    w_err_code    = 3'd0;
    w_cmderr_nxt  = r_cmderr;

    case (r_state)
      ST_IDLE: begin
        if (i_cmd_update && r_cmderr == 3'd0) begin
          if (w_cmdtype != 8'd0 || w_aarsize != LEGAL_AARSIZE) begin
            w_err_set  = 1'b1;
            w_err_code = 3'd2;
            w_fin_nxt  = 1'b1;
          end else if (!i_hart_halted) begin
            w_err_set  = 1'b1;
            w_err_code = 3'd4;
            w_fin_nxt  = 1'b1;
          end else if (!w_transfer) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b1;
            w_fin_nxt   = 1'b1;
            if (w_postinc) begin
              w_rinc_nxt  = 1'b1;
              w_rnext_nxt = w_cmd_regno + REGNO_WIDTH'(1);
            end
          end else begin
            w_state_nxt   = ST_REQ;
            w_busy_nxt    = 1'b1;
            w_req_nxt     = 1'b1;
            w_wr_nxt      = w_write;
            w_regno_nxt   = w_cmd_regno;
            w_wdata_nxt   = i_data0;
            w_postinc_nxt = w_postinc;
            w_cnt_nxt     = '0;
          end
        end
      end

      ST_REQ: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (i_reg_ack) begin
          w_state_nxt = ST_DONE;
          w_req_nxt   = 1'b0;
          w_fin_nxt   = 1'b1;
          if (i_reg_err) begin
            w_err_set  = 1'b1;
            w_err_code = 3'd3;
          end else begin
            if (!r_wr) begin
              w_d0data_nxt = i_reg_rdata;
              w_d0wr_nxt   = 1'b1;
            end
            if (r_postinc) begin
              w_rinc_nxt  = 1'b1;
              w_rnext_nxt = r_regno + REGNO_WIDTH'(1);
            end
          end
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = ST_DONE;
          w_req_nxt   = 1'b0;
          w_fin_nxt   = 1'b1;
          w_err_set   = 1'b1;
          w_err_code  = 3'd3;
        end
        // A command written while busy is dropped; the access carries on.
        if (i_cmd_update && !w_err_set) begin
          w_err_set  = 1'b1;
          w_err_code = 3'd1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        if (i_cmd_update) begin
          w_err_set  = 1'b1;
          w_err_code = 3'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // cmderr is sticky: only 0 -> nonzero, unless cleared; a set beats a clear.
    if (w_err_set && (r_cmderr == 3'd0 || i_cmderr_clr)) begin
      w_cmderr_nxt = w_err_code;
    end else if (i_cmderr_clr) begin
      w_cmderr_nxt = 3'd0;
    end
  end

  assign o_cmd_busy     = r_busy;
  assign o_cmderr       = r_cmderr;
  assign o_cmd_finished = r_fin;
  assign o_data0_wr     = r_d0wr;
  assign o_data0_wdata  = r_d0data;
  assign o_regno_inc    = r_rinc;
  assign o_regno_next   = r_rnext;
  assign o_reg_req      = r_req;
  assign o_reg_wr1_rd0  = r_wr;
  assign o_reg_regno    = r_regno;
  assign o_reg_wdata    = r_wdata;

endmodule

// File: tb/tb_abs_cmd_fsm.sv
// tb/tb_abs_cmd_fsm.sv - scoreboard testbench for abs_cmd_fsm
module tb_abs_cmd_fsm;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] command = '0;
  logic        cmd_update = 1'b0;
  logic [31:0] data0 = '0;
  logic        hart_halted = 1'b1;
  logic        cmderr_clr = 1'b0;
  logic        cmd_busy;
  logic [2:0]  cmderr;
  logic        cmd_finished;
  logic        data0_wr;
  logic [31:0] data0_wdata;
  logic        regno_inc;
  logic [15:0] regno_next;
  logic        reg_req;
  logic        reg_wr1_rd0;
  logic [15:0] reg_regno;
  logic [31:0] reg_wdata;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;
  logic [31:0] reg_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0]  err;
    logic        d0wr;
    logic [31:0] d0;
    logic        rinc;
    logic [15:0] rnext;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  abs_cmd_fsm dut (
    .i_sys_clk      (clk),
    .i_sys_rstn     (rstn),
    .i_command      (command),
    .i_cmd_update   (cmd_update),
    .i_data0        (data0),
    .i_hart_halted  (hart_halted),
    .i_cmderr_clr   (cmderr_clr),
    .o_cmd_busy     (cmd_busy),
    .o_cmderr       (cmderr),
    .o_cmd_finished (cmd_finished),
    .o_data0_wr     (data0_wr),
    .o_data0_wdata  (data0_wdata),
    .o_regno_inc    (regno_inc),
    .o_regno_next   (regno_next),
    .o_reg_req      (reg_req),
    .o_reg_wr1_rd0  (reg_wr1_rd0),
    .o_reg_regno    (reg_regno),
    .o_reg_wdata    (reg_wdata),
    .i_reg_ack      (reg_ack),
    .i_reg_err      (reg_err),
    .i_reg_rdata    (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_cmd(input logic [7:0] ct, input logic [2:0] sz,
                                         input logic pi, input logic tr, input logic wr,
                                         input logic [15:0] rn);
    return {ct, 1'b0, sz, pi, 1'b0, tr, wr, rn};
  endfunction

  task automatic push_exp(input logic [2:0] err, input logic d0wr, input logic [31:0] d0,
                          input logic rinc, input logic [15:0] rnext);
    exp_t e;
    e.err = err; e.d0wr = d0wr; e.d0 = d0; e.rinc = rinc; e.rnext = rnext;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    cmderr_clr = 1'b1;
    step();
    cmderr_clr = 1'b0;
    check_eq("cmderr_cleared", cmderr, 0);
  endtask

  // Issues a command at cycle 0 and acknowledges it at cycle ack_at.
  task automatic access(input logic [31:0] cmd, input logic [31:0] d0, input int ack_at,
                        input logic err, input logic [31:0] rdata);
    command = cmd; data0 = d0; cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    for (int c = 1; c < ack_at; c++) begin
      check_eq("req_hold", reg_req, 1);
      step();
    end
    check_eq("req_at_ack", reg_req, 1);
    reg_ack = 1'b1; reg_err = err; reg_rdata = rdata;
    step();
    reg_ack = 1'b0; reg_err = 1'b0;
    check_eq("req_dropped", reg_req, 0);
    check_eq("busy_in_done", cmd_busy, 1);
    step();
    check_eq("busy_cleared", cmd_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, cmd_busy, 0);
    check_eq({tag, "_cmderr"}, cmderr, 0);
    check_eq({tag, "_pulses"}, {cmd_finished, data0_wr, regno_inc}, 0);
    check_eq({tag, "_data0_wdata"}, data0_wdata, 0);
    check_eq({tag, "_regno_next"}, regno_next, 0);
    check_eq({tag, "_reg_req_wr"}, {reg_req, reg_wr1_rd0}, 0);
    check_eq({tag, "_reg_regno"}, reg_regno, 0);
    check_eq({tag, "_reg_wdata"}, reg_wdata, 0);
  endtask

  // Scoreboard monitor: every completion pulse pops one expected result.
  always @(negedge clk) begin
    if (rstn && cmd_finished) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_finish", 1, 0);
      end else begin
        m_e = sb.pop_front();
        check_eq("fin_cmderr", cmderr, m_e.err);
        check_eq("fin_data0_wr", data0_wr, m_e.d0wr);
        if (m_e.d0wr) check_eq("fin_data0_wdata", data0_wdata, m_e.d0);
        check_eq("fin_regno_inc", regno_inc, m_e.rinc);
        if (m_e.rinc) check_eq("fin_regno_next", regno_next, m_e.rnext);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    step();
    step();
    check_all_zero("reset");
    rstn = 1'b1;
    step();

    // 1: read 0x1001, ack at cycle 3
    push_exp(0, 1, 32'hDEADBEEF, 0, 0);
    command = mk_cmd(0, 2, 0, 1, 0, 16'h1001); cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    check_eq("t1_req_c1", reg_req, 1);
    check_eq("t1_rd", reg_wr1_rd0, 0);
    check_eq("t1_regno", reg_regno, 16'h1001);
    check_eq("t1_busy", cmd_busy, 1);
    step();
    check_eq("t1_req_c2", reg_req, 1);
    step();
    check_eq("t1_req_c3", reg_req, 1);
    reg_ack = 1'b1; reg_rdata = 32'hDEADBEEF;
    step();
    reg_ack = 1'b0;
    check_eq("t1_req_c4", reg_req, 0);
    check_eq("t1_busy_c4", cmd_busy, 1);
    step();
    check_eq("t1_busy_c5", cmd_busy, 0);

    // 2: write with postincrement, ack at cycle 1
    push_exp(0, 0, 0, 1, 16'h0301);
    command = mk_cmd(0, 2, 1, 1, 1, 16'h0300); data0 = 32'h12345678; cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    check_eq("t2_wr", reg_wr1_rd0, 1);
    check_eq("t2_wdata", reg_wdata, 32'h12345678);
    reg_ack = 1'b1; reg_rdata = 32'h0BAD0BAD;
    step();
    reg_ack = 1'b0;
    step();

    // 3: bad cmdtype, then ignored command, clear, then normal read
    push_exp(2, 0, 0, 0, 0);
    command = mk_cmd(2, 2, 0, 1, 0, 16'h0005); cmd_update = 1'b1;
    step();
    command = mk_cmd(0, 2, 0, 1, 0, 16'h0005);
    check_eq("t3_no_req", reg_req, 0);
    check_eq("t3_busy0", cmd_busy, 0);
    step();
    cmd_update = 1'b0;
    check_eq("t3_ignored_req", reg_req, 0);
    check_eq("t3_cmderr", cmderr, 2);
    clear_err();
    push_exp(0, 1, 32'h00C0FFEE, 0, 0);
    access(mk_cmd(0, 2, 0, 1, 0, 16'h0005), 0, 2, 0, 32'h00C0FFEE);

    // bad aarsize
    push_exp(2, 0, 0, 0, 0);
    command = mk_cmd(0, 3, 0, 1, 0, 16'h0005); cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    step();
    clear_err();

    // 4: collision during REQ keeps the original access
    push_exp(1, 1, 32'hA5A50042, 0, 0);
    command = mk_cmd(0, 2, 0, 1, 0, 16'h0042); cmd_update = 1'b1;
    step();
    command = mk_cmd(0, 2, 0, 1, 1, 16'h0777);
    step();
    cmd_update = 1'b0;
    check_eq("t4_cmderr1", cmderr, 1);
    check_eq("t4_regno_kept", reg_regno, 16'h0042);
    check_eq("t4_rd_kept", reg_wr1_rd0, 0);
    reg_ack = 1'b1; reg_rdata = 32'hA5A50042;
    step();
    reg_ack = 1'b0;
    step();
    clear_err();

    // hart not halted
    push_exp(4, 0, 0, 0, 0);
    hart_halted = 1'b0;
    command = mk_cmd(0, 2, 0, 1, 0, 16'h0010); cmd_update = 1'b1;
    step();
    cmd_update = 1'b0; hart_halted = 1'b1;
    check_eq("t4_halt_no_req", reg_req, 0);
    step();
    check_eq("t4_halt_cmderr", cmderr, 4);
    clear_err();

    // 5: timeout, then late ack ignored
    push_exp(3, 0, 0, 0, 0);
    command = mk_cmd(0, 2, 1, 1, 0, 16'h0020); cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    n = 0;
    while (reg_req && n < 200) begin
      n++;
      step();
    end
    check_eq("t5_req_cycles", n, 64);
    check_eq("t5_busy_done", cmd_busy, 1);
    step();
    reg_ack = 1'b1; reg_rdata = 32'h55555555;
    step();
    reg_ack = 1'b0;
    check_eq("t5_late_cmderr", cmderr, 3);
    check_eq("t5_late_busy", cmd_busy, 0);
    step();
    clear_err();

    // ack with error
    push_exp(3, 0, 0, 0, 0);
    access(mk_cmd(0, 2, 1, 1, 0, 16'h0030), 0, 2, 1, 32'h77777777);
    clear_err();

    // 6: postincrement wrap, transfer=0 postincrement
    push_exp(0, 1, 32'h13579BDF, 1, 16'h0000);
    access(mk_cmd(0, 2, 1, 1, 0, 16'hFFFF), 0, 1, 0, 32'h13579BDF);
    push_exp(0, 0, 0, 1, 16'h0011);
    command = mk_cmd(0, 2, 1, 0, 0, 16'h0010); cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    check_eq("t6_notx_busy", cmd_busy, 1);
    check_eq("t6_notx_req", reg_req, 0);
    step();
    check_eq("t6_notx_busy_off", cmd_busy, 0);

    // reset during REQ
    command = mk_cmd(0, 2, 0, 1, 1, 16'h4321); data0 = 32'hFEEDFACE; cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    check_eq("t6_pre_reset_req", reg_req, 1);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    #2;
    rstn = 1'b1;
    step();
    check_eq("t6_post_reset_req", reg_req, 0);
    push_exp(0, 0, 0, 0, 0);
    command = mk_cmd(0, 2, 0, 0, 0, 16'h0001); cmd_update = 1'b1;
    step();
    cmd_update = 1'b0;
    check_eq("t6_idle_accepts", cmd_busy, 1);
    step();
    step();

    check_eq("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/abs_cmd_fsm.md
Name: abs_cmd_fsm

Overview:
Parametrised, sequential abstract-command engine for the debug module.
- Decodes the `command` register written via dm_regs and validates it against the debug-spec rules.
- Runs a multi-cycle request/acknowledge handshake with the CSR/GPR file and reports busy/cmderr status.
- Returns read data into data0 and supports postincrement of regno.
- Sits between dm_regs and the core register-access port. It adds a wait-for-ack handshake, a timeout, error tracking and command rejection while busy.

Parameters:
DATA_WIDTH, 32, register access width; legal aarsize = log2(DATA_WIDTH/8).
REGNO_WIDTH, 16, regno field width.
TIMEOUT_CYCLES, 64, maximum REQ cycles before abort (at least 2).

Ports:
sys_clk  in  1  system clock
sys_rstn  in  1  asynchronous active-low reset
command  in  32  command register value (cmdtype[31:24], aarsize[22:20], postincrement[19], transfer[17], write[16], regno[15:0])
cmd_update  in  1  one-cycle pulse when command is written
data0  in  DATA_WIDTH  data0 register value
hart_halted  in  1  hart is halted
cmderr_clr  in  1  one-cycle pulse, W1C of abstractcs.cmderr
cmd_busy  out  1  abstractcs.busy
cmderr  out  3  abstractcs.cmderr
cmd_finished  out  1  one-cycle completion pulse
data0_wr  out  1  one-cycle pulse, write data0_wdata into data0
data0_wdata  out  DATA_WIDTH  read-back data
regno_inc  out  1  one-cycle pulse, write regno_next into command.regno
regno_next  out  REGNO_WIDTH  incremented regno
reg_req  out  1  access request, held until reg_ack or timeout
reg_wr1_rd0  out  1  1 = write, 0 = read
reg_regno  out  REGNO_WIDTH  target register number
reg_wdata  out  DATA_WIDTH  write data
reg_ack  in  1  access complete, single cycle
reg_err  in  1  access fault, qualified by reg_ack
reg_rdata  in  DATA_WIDTH  read data, qualified by reg_ack

Behaviour:
- Reset: state IDLE. All outputs are 0: cmd_busy, cmderr, cmd_finished, data0_wr, data0_wdata, regno_inc, regno_next, reg_req, reg_wr1_rd0, reg_regno, reg_wdata. Timeout counter is 0.
- Reset mid-operation aborts immediately. No ack is awaited.
- FSM states: IDLE, REQ, DONE.
- IDLE + cmd_update, evaluated in priority order:
  1. cmderr != 0: command ignored, no outputs.
  2. cmdtype != 0, or aarsize != log2(DATA_WIDTH/8): cmderr <= 2, cmd_finished pulses next cycle, busy stays 0.
  3. hart_halted = 0: cmderr <= 4, cmd_finished pulses next cycle.
  4. transfer = 0: no access. Go to DONE with busy = 1 for one cycle.
  5. Otherwise: latch write/regno/data0/postincrement into reg_wr1_rd0, reg_regno, reg_wdata. cmd_busy <= 1, reg_req <= 1, go to REQ.
- REQ:
  - reg_req held high and reg_* outputs stable. Counter increments each cycle.
  - reg_ack && !reg_err: if read, capture data0_wdata <= reg_rdata. Go to DONE, reg_req <= 0.
  - reg_ack && reg_err: cmderr <= 3, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: cmderr <= 3, reg_req <= 0, go to DONE. A late ack is ignored.
- DONE (one cycle):
  - cmd_finished = 1, cmd_busy <= 0 at end of cycle, counter cleared.
  - data0_wr = 1 only for a successful read.
  - regno_inc = 1 with regno_next = reg_regno + 1 (modulo 2^REGNO_WIDTH, FFFF wraps to 0000) only if postincrement=1 and the access succeeded (or transfer=0). Return to IDLE.
- Latency: cmd_update at cycle 0 gives reg_req high from cycle 1. Ack at cycle k gives cmd_finished/data0_wr/regno_inc at cycle k+1, and cmd_busy low from cycle k+2.
- cmd_update while cmd_busy=1: command discarded. cmderr <= 1 if cmderr == 0. The in-flight access continues unaffected.
- cmderr_clr sets cmderr <= 0. If it coincides with a new error set, the set wins.
- cmderr only changes from 0 to nonzero, except via cmderr_clr or reset.

Test Plan:
1. Read regno 0x1001, aarsize 2, ack after 3 cycles with rdata 0xDEADBEEF -> reg_req high cycles 1-3; data0_wr + cmd_finished at cycle 4 with data0_wdata=0xDEADBEEF; cmderr=0.
2. Write regno 0x0300, data0=0x12345678, postincrement=1, ack at cycle 1 -> reg_wr1_rd0=1, reg_wdata=0x12345678; regno_inc pulse with regno_next=0x0301; data0_wr stays 0.
3. cmdtype=2 -> cmderr=2, no reg_req. Next valid command ignored until cmderr_clr, then it executes normally.
4. Second cmd_update issued during REQ -> cmderr=1, first access completes with the original regno. Separately, hart_halted=0 -> cmderr=4.
5. No reg_ack -> reg_req drops after 64 cycles, cmderr=3, cmd_finished pulses. Ack with reg_err=1 -> cmderr=3, no data0_wr.
6. Postincrement at regno 0xFFFF -> regno_next=0x0000. sys_rstn asserted during REQ -> all outputs 0 immediately, FSM in IDLE.
